// File: rtl/apb4_ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// apb4_ps2_rx_ctrl
// APB4 PS/2 receive controller. The PS/2 clock and data pins are synchronised,
// and the clock is glitch filtered. A frame FSM assembles each 11-bit frame and
// aborts it on an inter-bit timeout. Good bytes are pushed into a receive FIFO.
// Parity, framing and overflow errors are kept as sticky status flags. A
// maskable level interrupt fires on a FIFO threshold or on an error.
//
// Ports
//   hclk, hrst        system clock (rising edge) / async active-high reset
//   paddr[11:0]       byte address, paddr[3:2] decoded
//   psel, penable     APB select / access phase
//   pwrite, pwdata    APB write strobe / write data
//   prdata[31:0]      read data, zero outside a read access phase
//   pready, pslverr   constant 1 / constant 0
//   ps2_clk_i         PS/2 clock pin (asynchronous)
//   ps2_dat_i         PS/2 data pin (asynchronous)
//   irq_o             registered level interrupt
//
// Register map
//   0x0 DATA  RO  [8] valid, [7:0] head byte; a read while non-empty pops
//   0x4 CTRL  RW  [0] en, [1] thr_ie, [2] err_ie, [CW+7:8] thresh
//   0x8 STAT  RO/W1C  [0] empty, [1] full, [2] par_err, [3] frm_err, [4] ovf,
//                     [CW+7:8] count
//   0xC       reads 0
// ---------------------------------------------------------------------------
module apb4_ps2_rx_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic [11:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {ST_IDLE, ST_RECV} state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0/p1: two-flop synchronisers for the asynchronous PS/2 pins
  // -------------------------------------------------------------------------
  logic clk_s_p0, clk_s_p1;
  logic dat_s_p0, dat_s_p1;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      clk_s_p0 <= 1'b1;
      clk_s_p1 <= 1'b1;
      dat_s_p0 <= 1'b1;
      dat_s_p1 <= 1'b1;
    end else begin
      clk_s_p0 <= ps2_clk_i;
      clk_s_p1 <= clk_s_p0;
      dat_s_p0 <= ps2_dat_i;
      dat_s_p1 <= dat_s_p0;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p2: clock glitch filter and falling-edge pulse
  // -------------------------------------------------------------------------
  logic          clk_f_p2;
  logic          fall_p2;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      clk_f_p2 <= 1'b1;
      fall_p2  <= 1'b0;
      filt_cnt <= '0;
    end else begin
      fall_p2 <= 1'b0;
      if (clk_s_p1 == clk_f_p2) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        // The new level was seen FILT_LEN times in a row: accept it.
        // A change away from a high level is a falling edge.
        clk_f_p2 <= clk_s_p1;
        filt_cnt <= '0;
        fall_p2  <= clk_f_p2;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM, bit counter and inter-bit timeout
  // -------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [3:0]    bc;
  logic [TW-1:0] tcnt;
  logic [8:0]    sh;
  logic          frame_end;
  logic          tmo;

  logic          ctrl_en, ctrl_thr_ie, ctrl_err_ie;
  logic [CW-1:0] ctrl_thresh;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ctrl_en && fall_p2 && !dat_s_p1) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else if (fall_p2) begin
          if (bc == 4'd9) begin
            frame_end = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          tmo       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      bc   <= '0;
      tcnt <= '0;
    end else if (state == ST_IDLE) begin
      bc   <= '0;
      tcnt <= '0;
    end else if (fall_p2) begin
      bc   <= bc + 4'd1;
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Bits enter at the top, so after nine shifts the first data bit sits at
  // sh[0] and the parity bit sits at sh[8].
  always_ff @(posedge hclk) begin
    if (state == ST_RECV && fall_p2 && bc != 4'd9) sh <= {dat_s_p1, sh[8:1]};
  end

  // -------------------------------------------------------------------------
  // Frame evaluation, FIFO and APB register file
  // -------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          par_err, frm_err, ovf;

  logic acc, rd_acc, wr_acc;
  logic frm_set, par_set, push_req, push, pop, ovf_set;
  logic w1c;

  assign acc    = psel & penable;
  assign rd_acc = acc & ~pwrite;
  assign wr_acc = acc & pwrite;
  assign w1c    = wr_acc && (paddr[3:2] == 2'd2);

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

  // Framing is checked first, then parity, then room in the FIFO.
  assign frm_set  = (frame_end && !dat_s_p1) || tmo;
  assign par_set  = frame_end && dat_s_p1 && !odd_parity(sh);
  assign push_req = frame_end && dat_s_p1 && odd_parity(sh);
  assign pop      = rd_acc && (paddr[3:2] == 2'd0) && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  always_ff @(posedge hclk) begin
    if (push) mem[wr_ptr] <= sh[7:0];
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ctrl_en     <= 1'b0;
      ctrl_thr_ie <= 1'b0;
      ctrl_err_ie <= 1'b0;
      ctrl_thresh <= '0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      ovf         <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (wr_acc && paddr[3:2] == 2'd1) begin
        ctrl_en     <= pwdata[0];
        ctrl_thr_ie <= pwdata[1];
        ctrl_err_ie <= pwdata[2];
        ctrl_thresh <= pwdata[8 +: CW];
      end

      // A new error in the same cycle as its clear wins.
      par_err <= par_set | (par_err & ~(w1c & pwdata[2]));
      frm_err <= frm_set | (frm_err & ~(w1c & pwdata[3]));
      ovf     <= ovf_set | (ovf     & ~(w1c & pwdata[4]));

      irq_o <= (ctrl_thr_ie && ctrl_thresh != '0 && count >= ctrl_thresh) ||
               (ctrl_err_ie && (par_err || frm_err || ovf));
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (paddr[3:2])
        2'd0: begin
          if (!empty) prdata[8:0] = {1'b1, mem[rd_ptr]};
        end
        2'd1: begin
          prdata[0]      = ctrl_en;
          prdata[1]      = ctrl_thr_ie;
          prdata[2]      = ctrl_err_ie;
          prdata[8 +: CW] = ctrl_thresh;
        end
        2'd2: begin
          prdata[0]      = empty;
          prdata[1]      = full;
          prdata[2]      = par_err;
          prdata[3]      = frm_err;
          prdata[4]      = ovf;
          prdata[8 +: CW] = count;
        end
        default: prdata = '0;
      endcase
    end
  end

  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{paddr[11:4], paddr[1:0], pwdata[31:CW+8], pwdata[7:5]};

endmodule
